// File: rtl/fwd_interlock_if.sv
// Pipeline-side bundle for the forwarding/interlock unit: ID/EX/stage inputs in,
// bypass selects and stall controls out.
interface fwd_interlock_if #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(NUM_STAGES + 2);

    logic [NUM_SRC*5-1:0]     id_src;
    logic [NUM_SRC-1:0]       id_src_used;
    logic                     id_long;
    logic [NUM_SRC*5-1:0]     ex_src;
    logic [4:0]               ex_rw;
    logic                     ex_regWr;
    logic [1:0]               ex_memtoreg;
    logic                     ex_long;
    logic [NUM_STAGES*5-1:0]  stg_rw;
    logic [NUM_STAGES-1:0]    stg_regWr;
    logic [NUM_STAGES*2-1:0]  stg_memtoreg;
    logic [NUM_STAGES*3-1:0]  stg_cp0op;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall;
    logic                     flush_ex;
    logic                     long_busy;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output id_src, id_src_used, id_long, ex_src, ex_rw, ex_regWr, ex_memtoreg,
               ex_long, stg_rw, stg_regWr, stg_memtoreg, stg_cp0op,
        input  fwd_sel, stall, flush_ex, long_busy, stall_cnt
    );

    modport slave (
        input  id_src, id_src_used, id_long, ex_src, ex_rw, ex_regWr, ex_memtoreg,
               ex_long, stg_rw, stg_regWr, stg_memtoreg, stg_cp0op,
        output fwd_sel, stall, flush_ex, long_busy, stall_cnt
    );
endinterface

// File: rtl/fwd_interlock_unit.sv
// EX-operand bypass selection, load-use / long-op interlock and stall generation.
// Optional stall-cycle counter enabled by defining FWD_STALL_CNT_EN.
module fwd_interlock_unit #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int LONG_LAT   = 4,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    fwd_interlock_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_STAGES + 2);
    localparam int LAT_W = $clog2(LONG_LAT + 1);
    localparam logic [SEL_W-1:0] SEL_SPECIAL = SEL_W'(NUM_STAGES + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD    = LAT_W'(LONG_LAT);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                   r_state, w_state_nxt;
    logic [4:0]               r_long_rw, w_long_rw_nxt;
    logic [LAT_W-1:0]         r_cnt, w_cnt_nxt;
    logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
    logic                     w_id_hit_ex, w_id_hit_long;
    logic                     w_load_use, w_long_haz, w_stall, w_capture;

    // Stages are scanned oldest to youngest so the youngest match is written last and wins.
    always_comb begin
        w_fwd_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.ex_src[5*k +: 5] != 5'd0) begin
                for (int j = NUM_STAGES - 1; j >= 0; j--) begin
                    if (bus.stg_regWr[j] && (bus.stg_rw[5*j +: 5] == bus.ex_src[5*k +: 5])) begin
                        w_fwd_sel[SEL_W*k +: SEL_W] =
                            ((bus.stg_memtoreg[2*j +: 2] == 2'd2) || (bus.stg_cp0op[3*j +: 3] == 3'b001))
                            ? SEL_SPECIAL : SEL_W'(j + 1);
                    end
                end
            end
        end
    end

    // NOTE: every variable gets a default before any condition, so no latch is inferred.
    always_comb begin
        w_id_hit_ex   = 1'b0;
        w_id_hit_long = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.id_src_used[k] && (bus.id_src[5*k +: 5] == bus.ex_rw))   w_id_hit_ex   = 1'b1;
            if (bus.id_src_used[k] && (bus.id_src[5*k +: 5] == r_long_rw))   w_id_hit_long = 1'b1;
        end
    end

    assign w_load_use = bus.ex_regWr && (bus.ex_memtoreg == 2'd1) && (bus.ex_rw != 5'd0) && w_id_hit_ex;
    assign w_long_haz = (r_state == ST_BUSY) &&
                        (bus.id_long || (w_id_hit_long && (r_long_rw != 5'd0)));
    assign w_stall    = w_load_use || w_long_haz;
    // A stalled cycle bubbles EX, so a long op sitting there must not be captured.
    assign w_capture  = bus.ex_long && bus.ex_regWr && !w_stall;

    always_comb begin
        w_state_nxt   = r_state;
        w_long_rw_nxt = r_long_rw;
        w_cnt_nxt     = r_cnt;
        if (w_capture) begin
            w_state_nxt   = ST_BUSY;
            w_long_rw_nxt = bus.ex_rw;
            w_cnt_nxt     = LAT_LOAD;
        end else if (r_state == ST_BUSY) begin
            if (r_cnt == LAT_W'(1)) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt - LAT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_long_rw <= 5'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_long_rw <= w_long_rw_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif

    assign bus.fwd_sel   = w_fwd_sel;
    assign bus.stall     = w_stall;
    assign bus.flush_ex  = w_stall;
    assign bus.long_busy = (r_state == ST_BUSY);
endmodule

// File: tb/tb_fwd_interlock_unit.sv
// Self-checking bench for fwd_interlock_unit: directed scenarios plus randomized
// traffic compared against a cycle-timestamp reference model.
module tb_fwd_interlock_unit;
    localparam int NUM_SRC    = 2;
    localparam int NUM_STAGES = 2;
    localparam int LONG_LAT   = 4;
    localparam int CNT_W      = 16;
    localparam int SEL_W      = $clog2(NUM_STAGES + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Reference model: the long op is busy while the edge count is below busy_end.
    longint cyc = 0;
    longint m_busy_end = 0;
    logic [4:0] m_rw = 5'd0;
    longint m_scnt = 0;

    always #5 clk = ~clk;

    fwd_interlock_if #(.NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES), .CNT_W(CNT_W)) bus ();

    fwd_interlock_unit #(
        .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES), .LONG_LAT(LONG_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [SEL_W-1:0] model_sel(input logic [4:0] src);
        if (src == 5'd0) return '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (bus.stg_regWr[j] && bus.stg_rw[5*j +: 5] == src) begin
                if (bus.stg_memtoreg[2*j +: 2] == 2'd2 || bus.stg_cp0op[3*j +: 3] == 3'b001)
                    return SEL_W'(NUM_STAGES + 1);
                return SEL_W'(j + 1);
            end
        end
        return '0;
    endfunction

    function automatic bit model_busy();
        return cyc < m_busy_end;
    endfunction

    function automatic bit model_stall();
        bit lu = 1'b0;
        bit lh = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.id_src_used[k] && bus.ex_regWr && bus.ex_memtoreg == 2'd1 &&
                bus.ex_rw != 5'd0 && bus.id_src[5*k +: 5] == bus.ex_rw) lu = 1'b1;
            if (bus.id_src_used[k] && m_rw != 5'd0 && bus.id_src[5*k +: 5] == m_rw) lh = 1'b1;
        end
        if (bus.id_long) lh = 1'b1;
        return lu || (model_busy() && lh);
    endfunction

    function automatic longint model_cnt();
`ifdef FWD_STALL_CNT_EN
        return m_scnt;
`else
        return 0;
`endif
    endfunction

    task automatic clear_inputs();
        bus.id_src = '0;       bus.id_src_used = '0;  bus.id_long = 1'b0;
        bus.ex_src = '0;       bus.ex_rw = '0;        bus.ex_regWr = 1'b0;
        bus.ex_memtoreg = '0;  bus.ex_long = 1'b0;
        bus.stg_rw = '0;       bus.stg_regWr = '0;    bus.stg_memtoreg = '0;
        bus.stg_cp0op = '0;
    endtask

    // Advance one clock: update the model from the pre-edge inputs, return at the falling edge.
    task automatic tick();
        bit st  = model_stall();
        bit cap = bus.ex_long && bus.ex_regWr && !st;
        logic [4:0] rw = bus.ex_rw;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (cap) begin
                m_busy_end = cyc + LONG_LAT;
                m_rw = rw;
            end
            if (st && m_scnt < (longint'(1) << CNT_W) - 1) m_scnt++;
        end else begin
            m_busy_end = cyc;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_busy_end = cyc;
        m_rw = 5'd0;
        m_scnt = 0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.flush_ex !== 1'b0 || bus.long_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: stall=%b flush_ex=%b long_busy=%b, required all 0",
                     bus.stall, bus.flush_ex, bus.long_busy);
        end
        checks++;
        if (bus.stall_cnt !== '0 || bus.fwd_sel !== '0) begin
            failures++;
            $display("FAIL reset_vals: stall_cnt=%0d fwd_sel=%0h, required 0/0", bus.stall_cnt, bus.fwd_sel);
        end
        apply_reset();
    endtask

    task automatic test_forwarding();
        logic [SEL_W-1:0] s;
        clear_inputs();
        bus.stg_rw = {5'd5, 5'd5}; bus.stg_regWr = 2'b11; bus.ex_src[4:0] = 5'd5;
        #1; s = bus.fwd_sel[SEL_W-1:0]; checks++;
        if (s !== 2'd1) begin failures++; $display("FAIL fwd_mem_wins: got %0d required 1", s); end
        bus.stg_regWr = 2'b10;
        #1; s = bus.fwd_sel[SEL_W-1:0]; checks++;
        if (s !== 2'd2) begin failures++; $display("FAIL fwd_wb: got %0d required 2", s); end
        bus.stg_regWr = 2'b00;
        #1; s = bus.fwd_sel[SEL_W-1:0]; checks++;
        if (s !== 2'd0) begin failures++; $display("FAIL fwd_none: got %0d required 0", s); end
        // MEM mfc0 to r7 must shadow an ordinary WB write of r7.
        clear_inputs();
        bus.stg_rw = {5'd7, 5'd7}; bus.stg_regWr = 2'b11; bus.stg_cp0op = {3'b000, 3'b001};
        bus.ex_src[9:5] = 5'd7;
        #1; s = bus.fwd_sel[2*SEL_W-1:SEL_W]; checks++;
        if (s !== 2'd3) begin failures++; $display("FAIL fwd_mfc0: got %0d required 3", s); end
        clear_inputs();
        bus.stg_rw = {5'd4, 5'd6}; bus.stg_regWr = 2'b11; bus.stg_memtoreg = {2'd2, 2'd0};
        bus.ex_src[9:5] = 5'd4;
        #1; s = bus.fwd_sel[2*SEL_W-1:SEL_W]; checks++;
        if (s !== 2'd3) begin failures++; $display("FAIL fwd_wb_special: got %0d required 3", s); end
        clear_inputs();
        bus.stg_regWr = 2'b01; bus.stg_rw = '0; bus.ex_src[9:5] = 5'd0;
        #1; s = bus.fwd_sel[2*SEL_W-1:SEL_W]; checks++;
        if (s !== 2'd0) begin failures++; $display("FAIL fwd_r0: got %0d required 0", s); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.ex_regWr = 1'b1; bus.ex_memtoreg = 2'd1; bus.ex_rw = 5'd3;
        bus.id_src[4:0] = 5'd3; bus.id_src_used = 2'b01;
        #1; checks++;
        if (bus.stall !== 1'b1 || bus.flush_ex !== 1'b1) begin
            failures++;
            $display("FAIL load_use: stall=%b flush_ex=%b required 1/1", bus.stall, bus.flush_ex);
        end
        tick();
        // The load has moved on to MEM; EX now holds the bubble.
        bus.ex_regWr = 1'b0; bus.ex_memtoreg = 2'd0; bus.ex_rw = 5'd0;
        #1; checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL load_use_release: stall=%b required 0", bus.stall); end
        bus.ex_regWr = 1'b1; bus.ex_memtoreg = 2'd1; bus.ex_rw = 5'd3; bus.id_src_used = 2'b00;
        #1; checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL load_use_unused: stall=%b required 0", bus.stall); end
        tick();
        clear_inputs();
    endtask

    task automatic run_long_window(input logic [4:0] rw, input bit use_id_long, input string tag);
        clear_inputs();
        bus.ex_long = 1'b1; bus.ex_regWr = 1'b1; bus.ex_rw = rw;
        tick();
        clear_inputs();
        if (use_id_long) bus.id_long = 1'b1;
        else begin bus.id_src[9:5] = rw; bus.id_src_used = 2'b10; end
        for (int i = 1; i <= LONG_LAT; i++) begin
            #1; checks++;
            if (bus.long_busy !== 1'b1 || bus.stall !== 1'b1 || bus.flush_ex !== 1'b1) begin
                failures++;
                $display("FAIL %s_cycle%0d: busy=%b stall=%b flush=%b required 1/1/1",
                         tag, i, bus.long_busy, bus.stall, bus.flush_ex);
            end
            tick();
        end
        #1; checks++;
        if (bus.long_busy !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL %s_release: busy=%b stall=%b required 0/0", tag, bus.long_busy, bus.stall);
        end
        clear_inputs();
    endtask

    task automatic test_long_op();
        run_long_window(5'd9, 1'b0, "long_src");
        run_long_window(5'd12, 1'b1, "long_idlong");
    endtask

    task automatic test_reset_mid_busy();
        clear_inputs();
        bus.ex_long = 1'b1; bus.ex_regWr = 1'b1; bus.ex_rw = 5'd9;
        tick();
        clear_inputs();
        bus.id_src[4:0] = 5'd9; bus.id_src_used = 2'b01;
        tick();
        tick();
        #1; checks++;
        if (bus.stall !== 1'b1 || bus.long_busy !== 1'b1) begin
            failures++;
            $display("FAIL midbusy_pre: stall=%b busy=%b required 1/1", bus.stall, bus.long_busy);
        end
        #1 rst_n = 1'b0;
        m_busy_end = cyc; m_rw = 5'd0; m_scnt = 0;
        #1; checks++;
        if (bus.stall !== 1'b0 || bus.flush_ex !== 1'b0 || bus.long_busy !== 1'b0 || bus.stall_cnt !== '0) begin
            failures++;
            $display("FAIL midbusy_reset: stall=%b flush=%b busy=%b cnt=%0d required 0/0/0/0",
                     bus.stall, bus.flush_ex, bus.long_busy, bus.stall_cnt);
        end
        rst_n = 1'b1;
        tick();
        #1; checks++;
        if (bus.stall !== 1'b0 || bus.long_busy !== 1'b0) begin
            failures++;
            $display("FAIL midbusy_after: stall=%b busy=%b required 0/0", bus.stall, bus.long_busy);
        end
        clear_inputs();
    endtask

    task automatic test_stall_cnt();
        longint want;
        apply_reset();
        for (int n = 0; n < 3; n++) begin
            clear_inputs();
            bus.ex_regWr = 1'b1; bus.ex_memtoreg = 2'd1; bus.ex_rw = 5'd3;
            bus.id_src[4:0] = 5'd3; bus.id_src_used = 2'b01;
            tick();
            clear_inputs();
            tick();
        end
        run_long_window(5'd9, 1'b0, "cnt_long");
`ifdef FWD_STALL_CNT_EN
        want = 7;
`else
        want = 0;
`endif
        checks++;
        if (longint'(bus.stall_cnt) != want) begin
            failures++;
            $display("FAIL stall_cnt: got %0d required %0d", bus.stall_cnt, want);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                bus.id_src[5*k +: 5] = 5'($urandom_range(0, 7));
                bus.ex_src[5*k +: 5] = 5'($urandom_range(0, 7));
            end
            bus.id_src_used = NUM_SRC'($urandom);
            bus.id_long     = ($urandom_range(0, 7) == 0);
            bus.ex_rw       = 5'($urandom_range(0, 7));
            bus.ex_regWr    = 1'($urandom);
            bus.ex_memtoreg = 2'($urandom);
            bus.ex_long     = ($urandom_range(0, 5) == 0);
            for (int j = 0; j < NUM_STAGES; j++) begin
                bus.stg_rw[5*j +: 5]       = 5'($urandom_range(0, 7));
                bus.stg_memtoreg[2*j +: 2] = 2'($urandom);
                bus.stg_cp0op[3*j +: 3]    = ($urandom_range(0, 3) == 0) ? 3'b001 : 3'($urandom);
            end
            bus.stg_regWr = NUM_STAGES'($urandom);
            #1;
            for (int k = 0; k < NUM_SRC; k++) begin
                checks++;
                if (bus.fwd_sel[SEL_W*k +: SEL_W] !== model_sel(bus.ex_src[5*k +: 5])) begin
                    failures++;
                    $display("FAIL rand_fwd[%0d] n=%0d: got %0d required %0d", k, n,
                             bus.fwd_sel[SEL_W*k +: SEL_W], model_sel(bus.ex_src[5*k +: 5]));
                end
            end
            checks++;
            if (bus.stall !== model_stall() || bus.flush_ex !== model_stall() ||
                bus.long_busy !== model_busy() || longint'(bus.stall_cnt) != model_cnt()) begin
                failures++;
                $display("FAIL rand_ctrl n=%0d: stall=%b flush=%b busy=%b cnt=%0d required %b/%b/%b/%0d",
                         n, bus.stall, bus.flush_ex, bus.long_busy, bus.stall_cnt,
                         model_stall(), model_stall(), model_busy(), model_cnt());
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_forwarding();
        test_load_use();
        test_long_op();
        test_reset_mid_busy();
        test_stall_cnt();
        apply_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fwd_interlock_unit.md
Name: fwd_interlock_unit

Overview:
Parameterised forwarding and interlock unit for the integer pipeline. It selects the bypass source for each EX-stage operand across NUM_STAGES downstream stages, with the youngest stage taking priority. It also detects load-use hazards and tracks one in-flight fixed-latency long operation (mul/div) with a small FSM and counter. It drives stall and bubble signals to the IF/ID/EX pipeline registers.

Parameters:
NUM_SRC, 2, number of operand sources per instruction (rs, rt, ...)
NUM_STAGES, 2, number of forwarding stages; stage 0 = MEM (youngest), stage 1 = WB, ...
LONG_LAT, 4, cycles a long op occupies the unit after leaving EX; legal range is ≥1
CNT_W, 16, width of the stall performance counter
(local) SEL_W = clog2(NUM_STAGES+2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id_src  in  NUM_SRC*5  ID-stage source regs; source k occupies bits [5k+4:5k]
id_src_used  in  NUM_SRC  source k is actually read by the ID instruction
id_long  in  1  ID instruction is a long op
ex_src  in  NUM_SRC*5  EX-stage source regs
ex_rw  in  5  EX destination register
ex_regWr  in  1  EX instruction writes a register
ex_memtoreg  in  2  EX writeback select; 1 = load, 2 = special (non-bypassable)
ex_long  in  1  EX instruction is a long op
stg_rw  in  NUM_STAGES*5  destination register per stage
stg_regWr  in  NUM_STAGES  register-write enable per stage
stg_memtoreg  in  NUM_STAGES*2  writeback select per stage
stg_cp0op  in  NUM_STAGES*3  CP0 op per stage; 3'b001 = mfc0
fwd_sel  out  NUM_SRC*SEL_W  bypass select per source
stall  out  1  freeze PC and IF/ID
flush_ex  out  1  insert bubble into ID/EX
long_busy  out  1  long op in flight
stall_cnt  out  CNT_W  stall-cycle count (see Optional Feature)

Behaviour:
- Forwarding is combinational and evaluated independently for each source k.
  - ex_src[k]==0 → sel 0 (register file).
  - Otherwise scan stages 0..NUM_STAGES-1 and take the first stage j with stg_regWr[j] && stg_rw[j]==ex_src[k].
    - If that stage has memtoreg==2 or cp0op==3'b001 → sel = NUM_STAGES+1 (special path).
    - Otherwise sel = j+1.
  - No matching stage → sel 0.
  - The youngest match always wins, even when it is special. Older stages are never consulted past it.
- Load-use hazard (combinational): ex_regWr && ex_memtoreg==1 && ex_rw!=0 && some k has id_src_used[k] && id_src[k]==ex_rw.
- FSM states IDLE and BUSY; registers long_rw[4:0] and cnt (clog2(LONG_LAT+1) bits).
  - IDLE→BUSY at a clock edge where ex_long && ex_regWr && !flush_ex. At that edge: long_rw←ex_rw, cnt←LONG_LAT.
  - In BUSY, cnt decrements every edge. At the edge where cnt==1 the FSM returns to IDLE with cnt←0, so BUSY lasts exactly LONG_LAT cycles.
  - ex_long qualifying while already in BUSY → recapture long_rw and reload cnt (newest op wins). ID interlock normally prevents this case.
- Long hazard: state==BUSY && (id_long || some k with id_src_used[k] && id_src[k]==long_rw && long_rw!=0).
- stall = load-use hazard | long hazard.
- flush_ex = stall, in the same cycle.
- long_busy = (state==BUSY).
- A load-use hazard stalls for one cycle only, because the load advances to MEM. Simultaneous load-use and long hazards produce a single stall.
- Reset (async, rst_n low, including mid-BUSY): state IDLE, cnt 0, long_rw 0, stall_cnt 0. stall, flush_ex and long_busy read 0; fwd_sel depends only on inputs.

Optional Feature:
FWD_STALL_CNT_EN
- Defined: stall_cnt increments on every clock edge where stall==1 and saturates at all-ones.
- Undefined: stall_cnt is tied to 0 and no counter register is built.

Test Plan:
- MEM and WB both write r5 (no special), ex_src[0]=5 → fwd_sel[0]=1 (MEM wins); with MEM regWr=0 → 2; with neither → 0.
- MEM writes r7 via mfc0 (cp0op=001), ex_src[1]=7 → fwd_sel[1]=3 (NUM_STAGES=2). With ex_src[1]=0 and MEM rw=0 → 0.
- EX is load to r3, ID reads r3 (used=1) → stall=1 and flush_ex=1 for one cycle. With used=0 → no stall.
- ex_long writing r9 with LONG_LAT=4 → long_busy high for exactly 4 cycles. ID reading r9 stalls during those cycles and releases on cycle 5. id_long=1 stalls for the same window.
- Drop rst_n mid-BUSY (cnt=2) → long_busy, stall and flush_ex go to 0 immediately. After release, ID reading long_rw does not stall.
- FWD_STALL_CNT_EN defined, 3 load-use stalls plus 4 long stalls → stall_cnt=7. With CNT_W=2 it saturates at 3. Undefined → stall_cnt stays 0.
